hs_sync_aligner: RTL and testbench

//  Bench-side HS lane receiver that sits directly downstream of the bit-delay line.
//  It consumes the delayed serial HS bit stream (LSB first) and hunts for the sync byte.

---
 rtl/dsi_tb_pkg.sv | 13 +
 rtl/hs_sync_aligner.sv | 90 +++++++++
 tb/tb_hs_sync_aligner.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsi_tb_pkg.sv
// Shared constants and state type for the DSI HS lane bench-side receivers.
package dsi_tb_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BIT_CNT_W   = 3;
  localparam logic [BYTE_W-1:0] HS_SYNC_BYTE = 8'hB8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } hs_state_e;

endpackage

// File: rtl/hs_sync_aligner.sv
// HS lane byte aligner: hunts for the sync byte in an LSB-first bit stream,
// then packs bits into bytes, flagging start-of-transmission and partial bursts.
module hs_sync_aligner
  import dsi_tb_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_BYTE = HS_SYNC_BYTE,
  parameter int unsigned       ERR_W     = 8,
  parameter                    DBG_STR   = "hs_sync_aligner"
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_en,
  input  logic              i_d,
  input  logic              i_hs_end,
  output logic              o_locked,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_byte_vld,
  output logic              o_sot,
  output logic              o_err,
  output logic [ERR_W-1:0]  o_err_cnt
);

  hs_state_e            r_state;
  logic [BYTE_W-1:0]    r_win;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 r_first_pend;
  logic [BYTE_W-1:0]    w_nxt_win;

  // Instance tag only; it shapes no hardware.
  if ($bits(DBG_STR) == 0) begin : g_untagged
  end

  assign w_nxt_win = {i_d, r_win[BYTE_W-1:1]};

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state      <= HUNT;
      r_win        <= '0;
      r_bit_cnt    <= '0;
      r_first_pend <= 1'b0;
      o_locked     <= 1'b0;
      o_byte       <= '0;
      o_byte_vld   <= 1'b0;
      o_sot        <= 1'b0;
      o_err        <= 1'b0;
      o_err_cnt    <= '0;
    end else begin
      o_byte_vld <= 1'b0;
      o_sot      <= 1'b0;
      o_err      <= 1'b0;
      // Burst end beats a simultaneous bit; a byte cut short counts as partial.
      if (i_hs_end) begin
        if (r_state == LOCKED && r_bit_cnt != '0) begin
          o_err <= 1'b1;
          if (o_err_cnt != '1) begin
            o_err_cnt <= o_err_cnt + ERR_W'(1);
          end
        end
        r_state      <= HUNT;
        r_win        <= '0;
        r_bit_cnt    <= '0;
        r_first_pend <= 1'b0;
        o_locked     <= 1'b0;
      end else if (i_en) begin
        r_win <= w_nxt_win;
        case (r_state)
          HUNT: begin
            if (w_nxt_win == SYNC_BYTE) begin
              r_state      <= LOCKED;
              r_bit_cnt    <= '0;
              r_first_pend <= 1'b1;
              o_locked     <= 1'b1;
            end
          end
          LOCKED: begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            if (r_bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
              o_byte       <= w_nxt_win;
              o_byte_vld   <= 1'b1;
              o_sot        <= r_first_pend;
              r_first_pend <= 1'b0;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hs_sync_aligner.sv
// Self-checking bench for hs_sync_aligner: directed scenarios plus random bursts
// compared every cycle against a queue-based model of the receiver.
module tb_hs_sync_aligner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       d   = 1'b0;
  logic       hs_end = 1'b0;
  logic       o_locked, o_byte_vld, o_sot, o_err;
  logic [7:0] o_byte, o_err_cnt;

  hs_sync_aligner dut (
    .i_clk(clk), .i_arst(rst), .i_en(en), .i_d(d), .i_hs_end(hs_end),
    .o_locked(o_locked), .o_byte(o_byte), .o_byte_vld(o_byte_vld),
    .o_sot(o_sot), .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: bits kept as queues, the sync search is a sliding
  // 8-bit history that starts zero-filled after reset or burst end.
  bit   m_hist[$];
  bit   m_bits[$];
  bit   m_locked, m_first;
  int   m_cnt;
  logic [7:0] e_byte;
  logic e_vld, e_sot, e_err, e_locked;

  function automatic logic [7:0] pack8(input bit q[$]);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic model_clear_hist();
    m_hist.delete();
    for (int i = 0; i < 8; i++) m_hist.push_back(1'b0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear_hist();
      m_bits.delete();
      m_locked = 0; m_first = 0; m_cnt = 0;
      e_byte = '0; e_vld = 0; e_sot = 0; e_err = 0; e_locked = 0;
    end else begin
      cyc++;
      e_vld = 0; e_sot = 0; e_err = 0;
      if (hs_end) begin
        if (m_locked && m_bits.size() != 0) begin
          e_err = 1;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        m_locked = 0; m_first = 0;
        m_bits.delete();
        model_clear_hist();
      end else if (en) begin
        m_hist.push_back(d);
        void'(m_hist.pop_front());
        if (!m_locked) begin
          if (pack8(m_hist) == 8'hB8) begin
            m_locked = 1; m_first = 1;
            m_bits.delete();
          end
        end else begin
          m_bits.push_back(d);
          if (m_bits.size() == 8) begin
            e_byte = pack8(m_bits);
            e_vld  = 1;
            e_sot  = m_first;
            m_first = 0;
            m_bits.delete();
          end
        end
      end
      e_locked = m_locked;
    end
  end

  // Event log used by the directed literal checks.
  int lg_byte[$];
  int lg_sot[$];
  int lg_cyc[$];
  int err_events;
  bit locked_seen;

  always @(negedge clk) begin
    if (!rst) begin
      check("locked",   32'(o_locked),   32'(e_locked));
      check("byte_vld", 32'(o_byte_vld), 32'(e_vld));
      check("sot",      32'(o_sot),      32'(e_sot));
      check("err",      32'(o_err),      32'(e_err));
      check("byte",     32'(o_byte),     32'(e_byte));
      check("err_cnt",  32'(o_err_cnt),  32'(m_cnt));
      if (o_byte_vld === 1'b1) begin
        lg_byte.push_back(int'(o_byte));
        lg_sot.push_back(int'(o_sot));
        lg_cyc.push_back(cyc);
      end
      if (o_err === 1'b1) err_events++;
      if (o_locked === 1'b1) locked_seen = 1;
    end
  end

  task automatic clear_log();
    lg_byte.delete(); lg_sot.delete(); lg_cyc.delete();
    err_events = 0; locked_seen = 0;
  endtask

  task automatic drive(input logic e, input logic b, input logic h);
    @(posedge clk); #1;
    en = e; d = b; hs_end = h;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, b[i], 1'b0);
      if (gap) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1; en = 0; d = 0; hs_end = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clear_log();
  endtask

  task automatic stream_test(input string tag, input bit gap, input int spacing);
    int exp_b[3] = '{1, 2, 3};
    int exp_s[3] = '{1, 0, 0};
    apply_reset();
    send_byte(8'h00, gap);
    send_byte(8'h00, gap);
    send_byte(8'hB8, gap);
    send_byte(8'h01, gap);
    send_byte(8'h02, gap);
    send_byte(8'h03, gap);
    idle(3);
    check({tag, "_locked"}, 32'(o_locked), 32'd1);
    check({tag, "_count"}, 32'(lg_byte.size()), 32'd3);
    for (int i = 0; i < lg_byte.size() && i < 3; i++) begin
      check({tag, "_byte"}, 32'(lg_byte[i]), 32'(exp_b[i]));
      check({tag, "_sot"},  32'(lg_sot[i]),  32'(exp_s[i]));
    end
    for (int i = 1; i < lg_cyc.size() && i < 3; i++)
      check({tag, "_spacing"}, 32'(lg_cyc[i] - lg_cyc[i-1]), 32'(spacing));
    drive(1'b0, 1'b0, 1'b1);
    idle(2);
    check({tag, "_end_noerr"}, 32'(err_events), 32'd0);
    check({tag, "_end_unlock"}, 32'(o_locked), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // 1: asynchronous reset in the middle of a locked byte
    apply_reset();
    send_byte(8'hB8, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    #2;
    check("t1_locked_pre", 32'(o_locked), 32'd1);
    @(posedge clk); #3;
    rst = 1;
    #1;
    check("t1_rst_locked", 32'(o_locked), 32'd0);
    check("t1_rst_byte",   32'(o_byte),   32'd0);
    check("t1_rst_vld",    32'(o_byte_vld), 32'd0);
    check("t1_rst_sot",    32'(o_sot),    32'd0);
    check("t1_rst_err",    32'(o_err),    32'd0);
    check("t1_rst_cnt",    32'(o_err_cnt), 32'd0);
    @(posedge clk); #1 rst = 0;
    idle(10);
    check("t1_no_relock", 32'(o_locked), 32'd0);
    check("t1_no_err", 32'(err_events), 32'd0);

    // 2 and 3: continuous and gapped streams
    stream_test("t2", 1'b0, 8);
    stream_test("t3", 1'b1, 16);

    // 4: burst ends after 5 bits of a byte
    apply_reset();
    send_byte(8'hB8, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'(i & 1), 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    idle(3);
    check("t4_bytes", 32'(lg_byte.size()), 32'd0);
    check("t4_err", 32'(err_events), 32'd1);
    check("t4_cnt", 32'(o_err_cnt), 32'd1);
    check("t4_locked", 32'(o_locked), 32'd0);

    // 5: burst end coincides with the 8th bit
    apply_reset();
    send_byte(8'hB8, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    idle(3);
    check("t5_bytes", 32'(lg_byte.size()), 32'd0);
    check("t5_err", 32'(err_events), 32'd1);
    check("t5_cnt", 32'(o_err_cnt), 32'd1);

    // 6: no sync in a B9 stream, then saturating partial-burst count
    apply_reset();
    for (int i = 0; i < 6; i++) send_byte(8'hB9, 1'b0);
    idle(2);
    check("t6_never_locked", 32'(locked_seen), 32'd0);
    for (int k = 0; k < 258; k++) begin
      send_byte(8'hB8, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
    end
    idle(3);
    check("t6_err_events", 32'(err_events), 32'd258);
    check("t6_cnt_sat", 32'(o_err_cnt), 32'hFF);

    // Random bursts: optional noise, optional sync, random bits with gaps
    apply_reset();
    for (int burst = 0; burst < 60; burst++) begin
      int noise = $urandom_range(0, 6);
      int nbits = $urandom_range(0, 40);
      for (int i = 0; i < noise; i++) drive(1'b1, 1'($urandom), 1'b0);
      if ($urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 8; i++) begin
          if ($urandom_range(0, 3) == 0) drive(1'b0, 1'($urandom), 1'b0);
          drive(1'b1, 1'(8'hB8 >> i), 1'b0);
        end
      end
      for (int i = 0; i < nbits; i++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'($urandom), 1'b0);
        drive(1'b1, 1'($urandom), 1'b0);
      end
      drive(1'($urandom), 1'($urandom), 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
